// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (IFU fetch / LSU load-store) arbiter in front of
// a single downstream memory port with a req/gnt + rvalid handshake.
//
// Ports
//   clk, rst            sole clock (rising edge), asynchronous active-low reset
//   ifu_reqValid/raddr  fetch request and address
//   ifu_respValid/rdata fetch completion pulse and fetched word
//   lsu_reqValid/addr/wen/wdata/wmask   load/store request
//   lsu_respValid/rdata access completion pulse and load data
//   mem_req/addr/wen/wdata/wmask        downstream request (held until mem_gnt)
//   mem_gnt, mem_rvalid, mem_rdata      downstream accept / completion / data
//   bus_err             one-cycle pulse alongside the response of a timed-out access
//
// Parameters
//   TIMEOUT   cycles allowed in REQ+WAIT before the access is aborted
//   ERR_DATA  read data returned for an aborted access
module mem_arbiter #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_reqValid,
  input  logic [31:0] ifu_raddr,
  output logic        ifu_respValid,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_reqValid,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_respValid,
  output logic [31:0] lsu_rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        bus_err
);

  localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t        state;
  logic          owner;       // 1 = LSU owns the current access
  logic          last_owner;  // 1 = LSU was served last
  logic [31:0]   addr_q;
  logic          wen_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wmask_q;
  logic [CW-1:0] cnt;
  logic          err_q;
  logic [31:0]   ifu_rdata_q;
  logic [31:0]   lsu_rdata_q;

  logic          pick_lsu;
  logic          timeout_hit;
  logic [CW-1:0] cnt_next;

  // On a tie the requester not served last wins.
  assign pick_lsu    = lsu_reqValid && (!ifu_reqValid || !last_owner);
  // Cycle k of REQ+WAIT sees cnt == k-1; the TIMEOUT-th cycle is the last one.
  assign timeout_hit = (cnt >= TO_LAST);
  assign cnt_next    = (cnt == '1) ? cnt : cnt + CW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_owner  <= 1'b0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      cnt         <= '0;
      err_q       <= 1'b0;
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ifu_reqValid || lsu_reqValid) begin
            owner   <= pick_lsu;
            addr_q  <= pick_lsu ? lsu_addr : ifu_raddr;
            wen_q   <= pick_lsu ? lsu_wen : 1'b0;
            wdata_q <= pick_lsu ? lsu_wdata : '0;
            wmask_q <= pick_lsu ? lsu_wmask : '0;
            cnt     <= '0;
            state   <= REQ;
          end
        end
        REQ: begin
          cnt <= cnt_next;
          if (mem_gnt) begin
            state <= WAIT;
          end else if (timeout_hit) begin
            if (owner) lsu_rdata_q <= ERR_DATA;
            else       ifu_rdata_q <= ERR_DATA;
            err_q <= 1'b1;
            state <= RESP;
          end
        end
        WAIT: begin
          cnt <= cnt_next;
          if (mem_rvalid) begin
            if (owner) lsu_rdata_q <= mem_rdata;
            else       ifu_rdata_q <= mem_rdata;
            state <= RESP;
          end else if (timeout_hit) begin
            if (owner) lsu_rdata_q <= ERR_DATA;
            else       ifu_rdata_q <= ERR_DATA;
            err_q <= 1'b1;
            state <= RESP;
          end
        end
        RESP: begin
          last_owner <= owner;
          err_q      <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode only state and latched registers.
  assign mem_req       = (state == REQ);
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign ifu_respValid = (state == RESP) && !owner;
  assign lsu_respValid = (state == RESP) && owner;
  assign bus_err       = (state == RESP) && err_q;
  assign ifu_rdata     = ifu_rdata_q;
  assign lsu_rdata     = lsu_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (TIMEOUT overridden to 8).
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        ifu_reqValid;
  logic [31:0] ifu_raddr;
  logic        ifu_respValid;
  logic [31:0] ifu_rdata;
  logic        lsu_reqValid;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_respValid;
  logic [31:0] lsu_rdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        bus_err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(
    .TIMEOUT (8),
    .ERR_DATA(32'hDEADBEEF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ifu_reqValid (ifu_reqValid),
    .ifu_raddr    (ifu_raddr),
    .ifu_respValid(ifu_respValid),
    .ifu_rdata    (ifu_rdata),
    .lsu_reqValid (lsu_reqValid),
    .lsu_addr     (lsu_addr),
    .lsu_wen      (lsu_wen),
    .lsu_wdata    (lsu_wdata),
    .lsu_wmask    (lsu_wmask),
    .lsu_respValid(lsu_respValid),
    .lsu_rdata    (lsu_rdata),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_wen      (mem_wen),
    .mem_wdata    (mem_wdata),
    .mem_wmask    (mem_wmask),
    .mem_gnt      (mem_gnt),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .bus_err      (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in the first REQ cycle: grant now, complete next cycle, check the
  // owner's pulse, then release the request and check the pulse is gone.
  task automatic complete(input bit lsu, input logic [31:0] addr,
                          input logic [31:0] rd, input string tag);
    check_eq({tag, " mem_req"}, 32'(mem_req), 32'd1);
    check_eq({tag, " mem_addr"}, mem_addr, addr);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    check_eq({tag, " wait mem_req"}, 32'(mem_req), 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = rd;
    step();
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    check_eq({tag, " ifu_respValid"}, 32'(ifu_respValid), 32'(!lsu));
    check_eq({tag, " lsu_respValid"}, 32'(lsu_respValid), 32'(lsu));
    check_eq({tag, " rdata"}, lsu ? lsu_rdata : ifu_rdata, rd);
    check_eq({tag, " bus_err"}, 32'(bus_err), 32'd0);
    if (lsu) lsu_reqValid = 1'b0;
    else     ifu_reqValid = 1'b0;
    step();
    check_eq({tag, " resp dropped"}, 32'({ifu_respValid, lsu_respValid}), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    ifu_reqValid = 1'b0; ifu_raddr = '0;
    lsu_reqValid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    step();
    step();
    check_eq("reset mem_req", 32'(mem_req), 32'd0);
    check_eq("reset mem_addr", mem_addr, 32'd0);
    check_eq("reset resp", 32'({ifu_respValid, lsu_respValid, bus_err}), 32'd0);
    check_eq("reset ifu_rdata", ifu_rdata, 32'd0);
    check_eq("reset lsu_rdata", lsu_rdata, 32'd0);

    // Basic fetch, accepted in the first cycle after reset release.
    rst = 1'b1;
    ifu_reqValid = 1'b1; ifu_raddr = 32'h8000_0000;
    check_eq("t1 idle mem_req", 32'(mem_req), 32'd0);
    step();
    check_eq("t1 mem_wen", 32'(mem_wen), 32'd0);
    complete(1'b0, 32'h8000_0000, 32'h0010_0093, "t1");

    // Simultaneous requests after reset: LSU first, then IFU.
    do_reset();
    ifu_reqValid = 1'b1; ifu_raddr = 32'h8000_0100;
    lsu_reqValid = 1'b1; lsu_addr  = 32'h8000_2000;
    step();
    complete(1'b1, 32'h8000_2000, 32'hA5A5_0001, "t2 lsu");
    step();
    complete(1'b0, 32'h8000_0100, 32'h0000_0013, "t2 ifu");
    check_eq("t2 lsu_rdata held", lsu_rdata, 32'hA5A5_0001);

    // LSU alone, then a tie: IFU wins because LSU was served last.
    lsu_reqValid = 1'b1; lsu_addr = 32'h8000_3000;
    step();
    complete(1'b1, 32'h8000_3000, 32'h1111_2222, "t2b lsu");
    ifu_reqValid = 1'b1; ifu_raddr = 32'h8000_0200;
    lsu_reqValid = 1'b1; lsu_addr  = 32'h8000_3004;
    step();
    complete(1'b0, 32'h8000_0200, 32'h3333_4444, "t2c ifu");
    step();
    complete(1'b1, 32'h8000_3004, 32'h5555_6666, "t2d lsu");

    // Store with grant delayed 4 cycles; request fields change after latching.
    lsu_reqValid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b1;
    lsu_wdata = 32'h1234_5678; lsu_wmask = 4'hF;
    step();
    for (int i = 0; i < 5; i++) begin
      check_eq("t3 mem_req", 32'(mem_req), 32'd1);
      check_eq("t3 mem_addr", mem_addr, 32'h8000_1000);
      check_eq("t3 mem_wen", 32'(mem_wen), 32'd1);
      check_eq("t3 mem_wdata", mem_wdata, 32'h1234_5678);
      check_eq("t3 mem_wmask", 32'(mem_wmask), 32'hF);
      if (i == 0) begin
        lsu_wdata = '0;
        lsu_addr  = '0;
      end
      mem_gnt = (i == 4);
      step();
    end
    mem_gnt = 1'b0;
    check_eq("t3 wait mem_req", 32'(mem_req), 32'd0);
    check_eq("t3 wait resp", 32'(lsu_respValid), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_ABCD;
    step();
    mem_rvalid = 1'b0; mem_rdata = '0;
    check_eq("t3 lsu_respValid", 32'(lsu_respValid), 32'd1);
    check_eq("t3 ifu_respValid", 32'(ifu_respValid), 32'd0);
    check_eq("t3 lsu_rdata", lsu_rdata, 32'h0000_ABCD);
    lsu_reqValid = 1'b0; lsu_wen = 1'b0;
    step();

    // Timeout in REQ after 8 cycles.
    ifu_reqValid = 1'b1; ifu_raddr = 32'h8000_0400;
    step();
    for (int i = 0; i < 8; i++) begin
      check_eq("t4 mem_req", 32'(mem_req), 32'd1);
      check_eq("t4 no resp", 32'({ifu_respValid, bus_err}), 32'd0);
      step();
    end
    check_eq("t4 bus_err", 32'(bus_err), 32'd1);
    check_eq("t4 ifu_respValid", 32'(ifu_respValid), 32'd1);
    check_eq("t4 ifu_rdata", ifu_rdata, 32'hDEAD_BEEF);
    check_eq("t4 mem_req dropped", 32'(mem_req), 32'd0);
    ifu_reqValid = 1'b0;
    step();
    check_eq("t4 bus_err pulse", 32'(bus_err), 32'd0);

    // Grant on the last allowed REQ cycle wins over timeout.
    ifu_reqValid = 1'b1; ifu_raddr = 32'h8000_0500;
    step();
    for (int i = 0; i < 8; i++) begin
      check_eq("t4b mem_req", 32'(mem_req), 32'd1);
      mem_gnt = (i == 7);
      step();
    end
    mem_gnt = 1'b0;
    check_eq("t4b in wait", 32'({mem_req, ifu_respValid, bus_err}), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0001;
    step();
    mem_rvalid = 1'b0;
    check_eq("t4b ifu_respValid", 32'(ifu_respValid), 32'd1);
    check_eq("t4b bus_err", 32'(bus_err), 32'd0);
    check_eq("t4b ifu_rdata", ifu_rdata, 32'hCAFE_0001);
    ifu_reqValid = 1'b0;
    step();

    // rvalid on the last allowed WAIT cycle wins over timeout.
    ifu_reqValid = 1'b1; ifu_raddr = 32'h8000_0600;
    step();
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check_eq("t4c no resp", 32'({ifu_respValid, bus_err}), 32'd0);
      mem_rvalid = (i == 6);
      mem_rdata  = 32'hCAFE_0002;
      step();
    end
    mem_rvalid = 1'b0;
    check_eq("t4c ifu_respValid", 32'(ifu_respValid), 32'd1);
    check_eq("t4c bus_err", 32'(bus_err), 32'd0);
    check_eq("t4c ifu_rdata", ifu_rdata, 32'hCAFE_0002);
    ifu_reqValid = 1'b0;
    step();

    // Reset asserted during WAIT.
    ifu_reqValid = 1'b1; ifu_raddr = 32'h8000_0700;
    step();
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    rst = 1'b0;
    #1;
    check_eq("t5 ifu_rdata cleared", ifu_rdata, 32'd0);
    check_eq("t5 mem_addr cleared", mem_addr, 32'd0);
    check_eq("t5 outputs cleared", 32'({mem_req, ifu_respValid, lsu_respValid, bus_err}), 32'd0);
    ifu_reqValid = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h1357_9BDF;
    step();
    mem_rvalid = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check_eq("t5 no resp", 32'({ifu_respValid, lsu_respValid}), 32'd0);
      step();
    end
    ifu_reqValid = 1'b1; ifu_raddr = 32'h8000_0800;
    step();
    complete(1'b0, 32'h8000_0800, 32'h0000_0297, "t5 post");

    // Spurious rvalid in IDLE and REQ is ignored.
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step();
    step();
    check_eq("t6 no resp", 32'({ifu_respValid, lsu_respValid, mem_req}), 32'd0);
    check_eq("t6 ifu_rdata", ifu_rdata, 32'h0000_0297);
    check_eq("t6 lsu_rdata", lsu_rdata, 32'd0);
    ifu_reqValid = 1'b1; ifu_raddr = 32'h8000_0900;
    mem_rvalid = 1'b0;
    step();
    mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0;
    check_eq("t6 req ignores rvalid", ifu_rdata, 32'h0000_0297);
    complete(1'b0, 32'h8000_0900, 32'h0000_0A5A, "t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the max cycles spent in REQ+WAIT before an abort.
REQ-002 Parameter ERR_DATA, default 32'hDEADBEEF, SHALL be the read data returned on an aborted transaction.
REQ-003 Ports SHALL be:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- ifu_reqValid  in  1  IFU fetch request
- ifu_raddr  in  32  fetch address
- ifu_respValid  out  1  fetch done, one-cycle pulse
- ifu_rdata  out  32  fetched instruction
- lsu_reqValid  in  1  LSU request
- lsu_addr  in  32  access address
- lsu_wen  in  1  1 = write
- lsu_wdata  in  32  store data
- lsu_wmask  in  4  byte-write mask
- lsu_respValid  out  1  access done, one-cycle pulse
- lsu_rdata  out  32  load data
- mem_req  out  1  downstream request
- mem_addr  out  32  downstream address
- mem_wen  out  1  downstream write enable
- mem_wdata  out  32  downstream write data
- mem_wmask  out  4  downstream byte mask
- mem_gnt  in  1  downstream accepts mem_req this cycle
- mem_rvalid  in  1  downstream completion (read data or write ack)
- mem_rdata  in  32  downstream read data
- bus_err  out  1  one-cycle pulse on timeout abort

Function
REQ-004 FSM states SHALL be IDLE, REQ, WAIT, RESP; reset state IDLE.
REQ-005 IDLE: if any reqValid high, latch winner's addr/wen/wdata/wmask (IFU: wen=0, wmask=0, wdata=0) and owner bit, go REQ; else stay.
REQ-006 Arbitration: only one valid -> it wins; both valid -> winner is the requester not granted last (last_owner flop, reset to IFU, so LSU wins the first tie).
REQ-007 REQ: mem_req=1 with latched fields driven; mem_gnt=1 -> WAIT; fields SHALL be stable while mem_req=1.
REQ-008 WAIT: mem_req=0; mem_rvalid=1 -> capture mem_rdata into owner's rdata register, go RESP.
REQ-009 mem_rvalid in IDLE/REQ/RESP SHALL be ignored.
REQ-010 RESP: owner's respValid=1 for exactly one cycle, last_owner updated, go IDLE; non-owner's respValid SHALL stay 0.
REQ-011 Writes SHALL complete identically (wait for mem_rvalid); lsu_rdata SHALL take mem_rdata as captured.
REQ-012 ifu_rdata/lsu_rdata SHALL hold their last captured value until the next capture for that owner.
REQ-013 Minimum latency: reqValid in cycle N (IDLE), mem_gnt in N+1, mem_rvalid in N+2 -> respValid in N+3.
REQ-014 Requesters hold reqValid and fields until respValid and deassert the following cycle; reqValid high in IDLE is a new request; request-field changes after latching SHALL have no effect.
REQ-015 Timeout counter (8+ bits, wide enough for TIMEOUT) clears on leaving IDLE, increments each cycle in REQ/WAIT; reaching TIMEOUT -> go RESP, owner rdata := ERR_DATA, bus_err=1 in the RESP cycle, mem_req dropped.
REQ-016 mem_gnt and timeout in same REQ cycle: grant wins (go WAIT); mem_rvalid and timeout in same WAIT cycle: data wins, no bus_err.
REQ-017 All outputs SHALL be registered or decoded from state/latched registers only (no combinational input-to-output path).

Reset
REQ-018 rst=0 SHALL immediately force IDLE, last_owner=IFU, counter=0, and all outputs to 0, including mid-transaction; the aborted transaction SHALL produce no respValid.
REQ-019 After rst rises, the first IDLE cycle SHALL accept requests.

Verification
REQ-020 IFU fetch 0x80000000, mem_gnt immediate, mem_rvalid next cycle with 0x00100093 -> ifu_respValid pulse 3 cycles after request, ifu_rdata=0x00100093, lsu_respValid=0.
REQ-021 Both requests same cycle after reset -> LSU served first, then IFU; mem_addr order LSU addr, IFU addr; one respValid pulse each.
REQ-022 LSU sw addr 0x80001000 wdata 0x12345678 wmask 4'hF, mem_gnt delayed 4 cycles -> mem_req high 5 cycles with stable fields, mem_wen=1, lsu_respValid after mem_rvalid.
REQ-023 TIMEOUT=8, no mem_gnt -> after 8 cycles in REQ: bus_err and ifu_respValid pulse together, ifu_rdata=0xDEADBEEF.
REQ-024 rst low during WAIT -> outputs 0 at once, no respValid; post-reset fetch completes normally.
REQ-025 Spurious mem_rvalid in IDLE with 0xFFFFFFFF -> no respValid, rdata registers unchanged.
